// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared types, mode codes and pixel conversion for the camera capture front end
package cam_pkg;

   localparam logic [1:0] MODE_RGB565 = 2'd0;
   localparam logic [1:0] MODE_GRAY   = 2'd1;
   localparam logic [1:0] MODE_RAW    = 2'd2;

   typedef enum logic {
      ST_WAIT_VS = 1'b0,
      ST_FRAME   = 1'b1
   } state_t;

   // Expand 5/6/5 components to 8 bits by replicating their top bits.
   function automatic logic [23:0] rgb565_to_888(input logic [15:0] p);
      logic [4:0] r;
      logic [5:0] g;
      logic [4:0] b;
      r = p[15:11];
      g = p[10:5];
      b = p[4:0];
      return {r, r[4:2], g, g[5:4], b, b[4:2]};
   endfunction

   // Mode 3 is treated as RGB565.
   function automatic logic [23:0] convert_pixel(input logic [1:0] mode,
                                                 input logic [7:0] b0,
                                                 input logic [7:0] b1);
      case (mode)
         MODE_GRAY:   return {b0, b0, b0};
         MODE_RAW:    return {8'h00, b0, b1};
         MODE_RGB565: return rgb565_to_888({b0, b1});
         default:     return rgb565_to_888({b0, b1});
      endcase
   endfunction

endpackage

// File: rtl/cam_capture_stream_if.sv
// rtl/cam_capture_stream_if.sv - pixel stream bundle between capture front end and frame-buffer writer
//   valid : head pixel present          ready : consumer accepts head
//   data  : {R,G,B}                     x, y  : pixel coordinates
//   sof   : first pixel of frame        eol   : last kept pixel of line
interface cam_capture_stream_if #(
   parameter int X_W = 10,
   parameter int Y_W = 9
) ();
   import cam_pkg::*;

   logic           valid;
   logic           ready;
   logic [23:0]    data;
   logic [X_W-1:0] x;
   logic [Y_W-1:0] y;
   logic           sof;
   logic           eol;

   modport master (output valid, data, x, y, sof, eol, input ready);
   modport slave  (input valid, data, x, y, sof, eol, output ready);

endinterface

// File: rtl/cam_sync_fifo.sv
// rtl/cam_sync_fifo.sv - first-word-fall-through FIFO holding captured pixel entries
//   push/wdata : write side, ignored when full unless a pop happens in the same cycle
//   pop        : consume head, ignored when empty
//   rdata      : current head (valid while ~empty)
//   empty/full : occupancy flags
module cam_sync_fifo
   import cam_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             empty,
   output logic             full
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rdata   = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

endmodule

// File: rtl/cam_capture_stream.sv
// rtl/cam_capture_stream.sv - oversampling camera capture, pixel assembly, crop/decimate and output stream
//   clk, rst_n          : system clock (>= 3x PCLK), async active-low reset
//   cam_pclk/hsync/vsync/data : raw camera port, sampled as data
//   mode, decim_en      : format select and 2:1 decimation, latched at each VSYNC rise
//   pix (master)        : pixel stream with coordinates, sof and eol
//   frame_done          : one-cycle pulse at VSYNC rise ending a captured frame
//   overflow, overflow_clr : sticky drop flag and its clear (set wins)
module cam_capture_stream
   import cam_pkg::*;
#(
   parameter int H_ACTIVE   = 640,
   parameter int V_ACTIVE   = 480,
   parameter int X_W        = 10,
   parameter int Y_W        = 9,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        cam_pclk,
   input  logic                        cam_hsync,
   input  logic                        cam_vsync,
   input  logic [7:0]                  cam_data,
   input  logic [1:0]                  mode,
   input  logic                        decim_en,
   cam_capture_stream_if.master        pix,
   output logic                        frame_done,
   output logic                        overflow,
   input  logic                        overflow_clr
);

   localparam int ENTRY_W = 26 + X_W + Y_W;
   localparam logic [X_W:0]   H_LIM   = (X_W+1)'(H_ACTIVE);
   localparam logic [Y_W:0]   V_LIM   = (Y_W+1)'(V_ACTIVE);
   localparam logic [X_W-1:0] H_EOL   = X_W'(H_ACTIVE - 1);
   localparam logic [X_W-1:0] H_EOL_D = X_W'(H_ACTIVE - 2);

   // Synchronisers: index 0 is the first stage.
   logic [2:0] pclk_sync;
   logic [2:0] hs_sync;
   logic [2:0] vs_sync;
   logic [7:0] data_s1, data_s2, data_s3;

   logic pe, vs_rise, hs_fall, href;
   logic [7:0] byte_in;

   state_t state, state_next;
   logic   frame_done_next;
   logic   capture;

   logic [1:0]     mode_q;
   logic           decim_q;
   logic           phase;
   logic [7:0]     b0;
   logic [X_W-1:0] x;
   logic [Y_W-1:0] y;
   logic           line_bytes;

   logic           keep;
   logic [X_W-1:0] x_inc, x_out;
   logic [Y_W-1:0] y_inc, y_out;
   logic           eol_now;

   logic               stg_valid;
   logic [ENTRY_W-1:0] stg_entry;
   logic [ENTRY_W-1:0] head;
   logic               fifo_empty, fifo_full, pop, ovf_set;

   // Data and HREF are taken from the third stage so they reflect the
   // camera bus just before PCLK was seen rising.
   assign pe      = pclk_sync[1] & ~pclk_sync[2];
   assign vs_rise = vs_sync[1] & ~vs_sync[2];
   assign hs_fall = hs_sync[2] & ~hs_sync[1];
   assign href    = hs_sync[2];
   assign byte_in = data_s3;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pclk_sync <= '0;
         hs_sync   <= '0;
         vs_sync   <= '0;
         data_s1   <= '0;
         data_s2   <= '0;
         data_s3   <= '0;
      end else begin
         pclk_sync <= {pclk_sync[1:0], cam_pclk};
         hs_sync   <= {hs_sync[1:0], cam_hsync};
         vs_sync   <= {vs_sync[1:0], cam_vsync};
         data_s1   <= cam_data;
         data_s2   <= data_s1;
         data_s3   <= data_s2;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_WAIT_VS;
      else        state <= state_next;
   end

   always_comb begin
      state_next      = state;
      frame_done_next = 1'b0;
      case (state)
         ST_WAIT_VS: if (vs_rise) state_next = ST_FRAME;
         ST_FRAME:   if (vs_rise) frame_done_next = 1'b1;
         default:    state_next = ST_WAIT_VS;
      endcase
   end

   assign capture = (state == ST_FRAME);

   always_comb begin
      keep    = ({1'b0, x} < H_LIM) && ({1'b0, y} < V_LIM) &&
                (!decim_q || (!x[0] && !y[0]));
      x_inc   = (x == '1) ? x : x + 1'b1;
      y_inc   = (y == '1) ? y : y + 1'b1;
      x_out   = decim_q ? {1'b0, x[X_W-1:1]} : x;
      y_out   = decim_q ? {1'b0, y[Y_W-1:1]} : y;
      eol_now = decim_q ? (x == H_EOL_D) : (x == H_EOL);
   end

   // VSYNC rise outranks HREF fall, which outranks a byte strobe, so an
   // aborted line never leaks a half-built pixel.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q     <= MODE_RGB565;
         decim_q    <= 1'b0;
         phase      <= 1'b0;
         b0         <= '0;
         x          <= '0;
         y          <= '0;
         line_bytes <= 1'b0;
         stg_valid  <= 1'b0;
         stg_entry  <= '0;
         frame_done <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         frame_done <= frame_done_next;
         stg_valid  <= 1'b0;
         if (vs_rise) begin
            mode_q     <= mode;
            decim_q    <= decim_en;
            phase      <= 1'b0;
            x          <= '0;
            y          <= '0;
            line_bytes <= 1'b0;
         end else if (capture && hs_fall) begin
            phase      <= 1'b0;
            x          <= '0;
            if (line_bytes) y <= y_inc;
            line_bytes <= 1'b0;
         end else if (capture && pe && href) begin
            line_bytes <= 1'b1;
            phase      <= ~phase;
            if (!phase) begin
               b0 <= byte_in;
            end else begin
               x         <= x_inc;
               stg_valid <= keep;
               stg_entry <= {(x == '0) && (y == '0), eol_now, y_out, x_out,
                             convert_pixel(mode_q, b0, byte_in)};
            end
         end
         if (ovf_set)           overflow <= 1'b1;
         else if (overflow_clr) overflow <= 1'b0;
      end
   end

   assign pop     = ~fifo_empty & pix.ready;
   assign ovf_set = stg_valid & fifo_full & ~pop;

   cam_sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (stg_valid),
      .wdata (stg_entry),
      .pop   (pop),
      .rdata (head),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   // Gate the head so the stream outputs read zero while nothing is queued.
   always_comb begin
      pix.valid = ~fifo_empty;
      pix.data  = fifo_empty ? '0 : head[23:0];
      pix.x     = fifo_empty ? '0 : head[24 +: X_W];
      pix.y     = fifo_empty ? '0 : head[24 + X_W +: Y_W];
      pix.eol   = fifo_empty ? 1'b0 : head[ENTRY_W-2];
      pix.sof   = fifo_empty ? 1'b0 : head[ENTRY_W-1];
   end

endmodule

// File: tb/tb_cam_capture_stream.sv
// tb/tb_cam_capture_stream.sv - self-checking bench for cam_capture_stream
module tb_cam_capture_stream;
   import cam_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cam_pclk = 1'b0;
   logic       cam_hsync = 1'b0;
   logic       cam_vsync = 1'b0;
   logic [7:0] cam_data = 8'h00;
   logic [1:0] mode = 2'd0;
   logic       decim_en = 1'b0;
   logic       overflow_clr = 1'b0;
   logic       frame_done;
   logic       overflow;

   always #5 clk = ~clk;

   cam_capture_stream_if #(.X_W(10), .Y_W(9)) pix ();

   cam_capture_stream #(
      .H_ACTIVE   (4),
      .V_ACTIVE   (8),
      .X_W        (10),
      .Y_W        (9),
      .FIFO_DEPTH (16)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cam_pclk     (cam_pclk),
      .cam_hsync    (cam_hsync),
      .cam_vsync    (cam_vsync),
      .cam_data     (cam_data),
      .mode         (mode),
      .decim_en     (decim_en),
      .pix          (pix),
      .frame_done   (frame_done),
      .overflow     (overflow),
      .overflow_clr (overflow_clr)
   );

   typedef struct {
      logic [23:0] data;
      int          x;
      int          y;
      logic        sof;
      logic        eol;
   } rec_t;

   typedef struct {
      logic [1:0]  mode;
      logic [7:0]  b0;
      logic [7:0]  b1;
      logic [23:0] exp;
   } vec_t;

   rec_t got[$];
   int   fd_count = 0;
   int   errors = 0;
   int   checks = 0;

   always @(negedge clk) begin
      rec_t r;
      if (pix.valid && pix.ready) begin
         r.data = pix.data;
         r.x    = int'(pix.x);
         r.y    = int'(pix.y);
         r.sof  = pix.sof;
         r.eol  = pix.eol;
         got.push_back(r);
      end
      if (frame_done) fd_count++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_pix(input string name, input int idx, input logic [23:0] d,
                            input int ex, input int ey, input logic sof, input logic eol);
      if (idx >= got.size()) begin
         checks++;
         errors++;
         $display("FAIL %s[%0d]: pixel missing, got %0d pixels", name, idx, got.size());
      end else begin
         check($sformatf("%s[%0d].data", name, idx), got[idx].data, d);
         check($sformatf("%s[%0d].x", name, idx), got[idx].x, ex);
         check($sformatf("%s[%0d].y", name, idx), got[idx].y, ey);
         check($sformatf("%s[%0d].sof", name, idx), got[idx].sof, sof);
         check($sformatf("%s[%0d].eol", name, idx), got[idx].eol, eol);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic cam_byte(input logic [7:0] b);
      cam_data = b;
      tick(3);
      cam_pclk = 1'b1;
      tick(3);
      cam_pclk = 1'b0;
   endtask

   task automatic line_start();
      cam_hsync = 1'b1;
      tick(2);
   endtask

   task automatic line_end();
      tick(2);
      cam_hsync = 1'b0;
      tick(4);
   endtask

   // Raw-mode friendly line: pixel i carries bytes {tag, i}.
   task automatic send_line(input int npix, input logic [7:0] tag);
      line_start();
      for (int i = 0; i < npix; i++) begin
         cam_byte(tag);
         cam_byte(8'(i));
      end
      line_end();
   endtask

   task automatic vsync_pulse();
      cam_vsync = 1'b1;
      tick(4);
      cam_vsync = 1'b0;
      tick(4);
   endtask

   vec_t vecs[9];

   initial begin
      int fd0;
      vecs[0] = '{2'd0, 8'hF8, 8'h00, 24'hFF0000};
      vecs[1] = '{2'd0, 8'h07, 8'hE0, 24'h00FF00};
      vecs[2] = '{2'd0, 8'h00, 8'h1F, 24'h0000FF};
      vecs[3] = '{2'd0, 8'h84, 8'h10, 24'h848284};
      vecs[4] = '{2'd1, 8'h80, 8'h10, 24'h808080};
      vecs[5] = '{2'd1, 8'h40, 8'h20, 24'h404040};
      vecs[6] = '{2'd2, 8'h12, 8'h34, 24'h001234};
      vecs[7] = '{2'd2, 8'hAB, 8'hCD, 24'h00ABCD};
      vecs[8] = '{2'd3, 8'hF8, 8'h00, 24'hFF0000};

      pix.ready = 1'b1;
      tick(3);
      check("reset.valid", pix.valid, 0);
      check("reset.overflow", overflow, 0);
      check("reset.frame_done", frame_done, 0);
      rst_n = 1'b1;
      tick(2);
      check("idle.data", pix.data, 0);

      // Bytes before any VSYNC must be discarded.
      send_line(2, 8'h55);
      tick(4);
      check("pre_vsync.count", got.size(), 0);

      // Single-pixel frames through every conversion mode.
      for (int i = 0; i < 9; i++) begin
         mode = vecs[i].mode;
         vsync_pulse();
         got.delete();
         line_start();
         cam_byte(vecs[i].b0);
         cam_byte(vecs[i].b1);
         line_end();
         tick(4);
         check($sformatf("vec%0d.count", i), got.size(), 1);
         check_pix($sformatf("vec%0d", i), 0, vecs[i].exp, 0, 0, 1'b1, 1'b0);
      end

      // RGB565 line of four pixels.
      mode = 2'd0;
      vsync_pulse();
      got.delete();
      line_start();
      cam_byte(8'hF8); cam_byte(8'h00);
      cam_byte(8'h07); cam_byte(8'hE0);
      cam_byte(8'h00); cam_byte(8'h1F);
      cam_byte(8'hFF); cam_byte(8'hFF);
      line_end();
      tick(4);
      check("rgb.count", got.size(), 4);
      check_pix("rgb", 0, 24'hFF0000, 0, 0, 1'b1, 1'b0);
      check_pix("rgb", 1, 24'h00FF00, 1, 0, 1'b0, 1'b0);
      check_pix("rgb", 2, 24'h0000FF, 2, 0, 1'b0, 1'b0);
      check_pix("rgb", 3, 24'hFFFFFF, 3, 0, 1'b0, 1'b1);

      // Gray mode; a mid-frame mode change must not take effect.
      mode = 2'd1;
      vsync_pulse();
      mode = 2'd0;
      got.delete();
      line_start();
      cam_byte(8'h80); cam_byte(8'h10);
      cam_byte(8'h40); cam_byte(8'h20);
      line_end();
      tick(4);
      check("gray.count", got.size(), 2);
      check_pix("gray", 0, 24'h808080, 0, 0, 1'b1, 1'b0);
      check_pix("gray", 1, 24'h404040, 1, 0, 1'b0, 1'b0);

      // Horizontal crop: 6 pixels per line, 4 kept.
      mode = 2'd2;
      vsync_pulse();
      got.delete();
      send_line(6, 8'h00);
      send_line(6, 8'h01);
      tick(4);
      check("crop.count", got.size(), 8);
      for (int k = 0; k < 8; k++)
         check_pix("crop", k, {8'h00, 8'(k / 4), 8'(k % 4)}, k % 4, k / 4, k == 0, (k % 4) == 3);
      fd0 = fd_count;
      vsync_pulse();
      check("crop.frame_done_cycles", fd_count - fd0, 1);

      // 2:1 decimation of a 4x4 frame.
      decim_en = 1'b1;
      vsync_pulse();
      decim_en = 1'b0;
      got.delete();
      for (int l = 0; l < 4; l++) send_line(4, 8'(l));
      tick(4);
      check("decim.count", got.size(), 4);
      check_pix("decim", 0, 24'h000000, 0, 0, 1'b1, 1'b0);
      check_pix("decim", 1, 24'h000002, 1, 0, 1'b0, 1'b1);
      check_pix("decim", 2, 24'h000200, 0, 1, 1'b0, 1'b0);
      check_pix("decim", 3, 24'h000202, 1, 1, 1'b0, 1'b1);

      // Back-pressure: 20 pixels into a 16-entry FIFO.
      pix.ready = 1'b0;
      vsync_pulse();
      got.delete();
      for (int l = 0; l < 5; l++) send_line(4, 8'(l));
      tick(4);
      check("ovf.flag", overflow, 1);
      check("ovf.valid", pix.valid, 1);
      check("ovf.head", pix.data, 24'h000000);
      overflow_clr = 1'b1;
      tick(1);
      overflow_clr = 1'b0;
      check("ovf.cleared", overflow, 0);
      pix.ready = 1'b1;
      tick(40);
      check("ovf.drain_count", got.size(), 16);
      for (int k = 0; k < 16; k++)
         check_pix("ovf", k, {8'h00, 8'(k / 4), 8'(k % 4)}, k % 4, k / 4, k == 0, (k % 4) == 3);
      check("ovf.empty_after", pix.valid, 0);

      // Partial pixel cut by HREF fall; next line restarts at x=0.
      vsync_pulse();
      got.delete();
      line_start();
      cam_byte(8'h10); cam_byte(8'h11); cam_byte(8'h12);
      line_end();
      send_line(2, 8'h20);
      tick(4);
      check("partial.count", got.size(), 3);
      check_pix("partial", 0, 24'h001011, 0, 0, 1'b1, 1'b0);
      check_pix("partial", 1, 24'h002000, 0, 1, 1'b0, 1'b0);
      check_pix("partial", 2, 24'h002001, 1, 1, 1'b0, 1'b0);

      // Reset mid-line: nothing captured until the next VSYNC.
      vsync_pulse();
      got.delete();
      line_start();
      cam_byte(8'h30);
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      cam_byte(8'h31);
      cam_byte(8'h32);
      cam_byte(8'h33);
      line_end();
      send_line(2, 8'h40);
      tick(6);
      check("rst_mid.count", got.size(), 0);
      check("rst_mid.valid", pix.valid, 0);
      check("rst_mid.overflow", overflow, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
